// File: rtl/alu_input_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_input_sequencer
//  Purpose  : Front-end controller for the board-level ALU. Each raw push
//             button is synchronised and debounced. A qualified press captures
//             the switch bank into operand A, operand B or the opcode register.
//             The block also pulses an update strobe whenever a load leaves
//             the full operand/opcode set populated.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK       in   1          system clock, rising edge
//    RESET     in   1          asynchronous, active-high reset
//    SWITCHES  in   SIZEDATA   quasi-static data/opcode switch bank
//    BUTTONS   in   N_BUTTONS  raw push-buttons {OP, B, A}, bouncing, async
//    DATA_A    out  SIZEDATA   registered operand A
//    DATA_B    out  SIZEDATA   registered operand B
//    OPCODE    out  SIZEOP     registered ALU operation code
//    LOADED    out  3          sticky "written since reset" flags {OP, B, A}
//    UPDATE    out  1          one-cycle pulse: a load completed the full set
// ============================================================================
module alu_input_sequencer #(
    parameter int SIZEDATA        = 8,
    parameter int N_BUTTONS       = 3,
    parameter int SIZEOP          = 6,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [SIZEDATA-1:0]  SWITCHES,
    input  logic [N_BUTTONS-1:0] BUTTONS,
    output logic [SIZEDATA-1:0]  DATA_A,
    output logic [SIZEDATA-1:0]  DATA_B,
    output logic [SIZEOP-1:0]    OPCODE,
    output logic [2:0]           LOADED,
    output logic                 UPDATE
);

    // Counter is wide enough to hold DEBOUNCE_CYCLES, where it saturates.
    localparam int                C_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_MAX  = C_CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [C_CNT_W-1:0] C_CNT_FIRE = C_CNT_W'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Two-flop synchroniser for every button
    // ------------------------------------------------------------------
    logic [N_BUTTONS-1:0] ff1_q;
    logic [N_BUTTONS-1:0] sync_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ff1_q  <= '0;
            sync_q <= '0;
        end else begin
            ff1_q  <= BUTTONS;
            sync_q <= ff1_q;
        end
    end

    // ------------------------------------------------------------------
    // Per-button debounce counter and press detector
    // ------------------------------------------------------------------
    logic [N_BUTTONS-1:0] press;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_button
        logic [C_CNT_W-1:0] cnt_q;
        logic [C_CNT_W-1:0] cnt_d;

        // Any low synchronised sample restarts qualification. The counter
        // saturates so a long hold cannot wrap around and re-fire.
        always_comb begin
            cnt_d = cnt_q;
            if (!sync_q[i]) begin
                cnt_d = '0;
            end else if (cnt_q < C_CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        // The counter passes DEBOUNCE_CYCLES-1 exactly once per held press,
        // which makes this a single-cycle event without an edge detector.
        assign press[i] = sync_q[i] && (cnt_q == C_CNT_FIRE);
    end

    // ------------------------------------------------------------------
    // Operand / opcode capture and completion tracking
    // ------------------------------------------------------------------
    logic [SIZEDATA-1:0] data_a_q, data_a_d;
    logic [SIZEDATA-1:0] data_b_q, data_b_d;
    logic [SIZEOP-1:0]   opcode_q, opcode_d;
    logic [2:0]          loaded_q, loaded_d;
    logic                update_q, update_d;

    // Simultaneous presses are all honoured in the same cycle; each target
    // simply takes the current switch value, so no priority is needed.
    always_comb begin
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        opcode_d = opcode_q;
        loaded_d = loaded_q | press[2:0];
        update_d = 1'b0;

        if (press[0]) begin
            data_a_d = SWITCHES;
        end
        if (press[1]) begin
            data_b_d = SWITCHES;
        end
        if (press[2]) begin
            opcode_d = SWITCHES[SIZEOP-1:0];
        end

        // One pulse per load cycle, however many loads coincide.
        update_d = (|press) && (loaded_d == 3'b111);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            data_a_q <= '0;
            data_b_q <= '0;
            opcode_q <= '0;
            loaded_q <= '0;
            update_q <= 1'b0;
        end else begin
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            opcode_q <= opcode_d;
            loaded_q <= loaded_d;
            update_q <= update_d;
        end
    end

    assign DATA_A = data_a_q;
    assign DATA_B = data_b_q;
    assign OPCODE = opcode_q;
    assign LOADED = loaded_q;
    assign UPDATE = update_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_input_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_input_sequencer
//  Purpose  : Self-checking bench for alu_input_sequencer (debounce of 4).
//             Inputs change on the falling edge; outputs are compared on the
//             falling edge against hand-written vectors and against a
//             history-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_input_sequencer;

    localparam int D = 4;

    logic       clk;
    logic       rst;
    logic [7:0] sw;
    logic [2:0] btn;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic [5:0] opcode;
    logic [2:0] loaded;
    logic       update;

    alu_input_sequencer #(
        .SIZEDATA        (8),
        .N_BUTTONS       (3),
        .SIZEOP          (6),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .CLK      (clk),
        .RESET    (rst),
        .SWITCHES (sw),
        .BUTTONS  (btn),
        .DATA_A   (data_a),
        .DATA_B   (data_b),
        .OPCODE   (opcode),
        .LOADED   (loaded),
        .UPDATE   (update)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs();
        return {6'd0, data_a, data_b, opcode, loaded, update};
    endfunction

    // ------------------------------------------------------------------
    // Reference model: a button loads at edge n when it was sampled high on
    // the D edges n-D-1 .. n-2 and low on edge n-D-2 (anything before
    // reset counts as low). Built from a log of sampled button values.
    // ------------------------------------------------------------------
    logic [2:0] hist[$];
    logic [7:0] exp_a, exp_b;
    logic [5:0] exp_op;
    logic [2:0] exp_ld;
    logic       exp_upd;

    function automatic logic bval(input int i, input int j);
        logic [2:0] t;
        if (j < 1 || j > hist.size()) return 1'b0;
        t = hist[j-1];
        return t[i];
    endfunction

    task automatic model_clear();
        hist.delete();
        exp_a = '0; exp_b = '0; exp_op = '0; exp_ld = '0; exp_upd = 1'b0;
    endtask

    task automatic model_step();
        logic [2:0] p;
        logic       q;
        int         n;
        hist.push_back(btn);
        n = hist.size();
        p = '0;
        for (int i = 0; i < 3; i++) begin
            q = 1'b1;
            for (int j = n - D - 1; j <= n - 2; j++) if (!bval(i, j)) q = 1'b0;
            if (bval(i, n - D - 2)) q = 1'b0;
            p[i] = q;
        end
        if (p[0]) exp_a  = sw;
        if (p[1]) exp_b  = sw;
        if (p[2]) exp_op = sw[5:0];
        exp_ld  = exp_ld | p;
        exp_upd = (p != 3'b000) && (exp_ld == 3'b111);
    endtask

    // One clock: model follows the rising edge, outputs checked on the fall.
    task automatic tick();
        @(posedge clk);
        if (rst) model_clear(); else model_step();
        @(negedge clk);
        chk("model", outs(), {6'd0, exp_a, exp_b, exp_op, exp_ld, exp_upd});
    endtask

    // Asynchronous assertion is checked before any clock edge can occur.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("async_reset", outs(), 32'd0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [2:0] btn;
        logic [7:0] sw;
        int         ncyc;
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [2:0] ld;
        logic       upd;
    } vec_t;

    vec_t tbl[16];

    int         hold[3];
    logic [2:0] lvl;

    initial begin
        // Directed vectors; expected values worked out by hand.
        tbl[0]  = '{3'b001, 8'h3C,  6, 8'h3C, 8'h00, 6'h00, 3'b001, 1'b0}; // basic load, edge 6
        tbl[1]  = '{3'b001, 8'hFF, 50, 8'h3C, 8'h00, 6'h00, 3'b001, 1'b0}; // held: no reload
        tbl[2]  = '{3'b000, 8'hFF,  2, 8'h3C, 8'h00, 6'h00, 3'b001, 1'b0};
        tbl[3]  = '{3'b010, 8'h55,  3, 8'h3C, 8'h00, 6'h00, 3'b001, 1'b0}; // too short
        tbl[4]  = '{3'b000, 8'h55,  1, 8'h3C, 8'h00, 6'h00, 3'b001, 1'b0};
        tbl[5]  = '{3'b010, 8'h55,  1, 8'h3C, 8'h00, 6'h00, 3'b001, 1'b0}; // bounce 1-0-1-1
        tbl[6]  = '{3'b000, 8'h55,  1, 8'h3C, 8'h00, 6'h00, 3'b001, 1'b0};
        tbl[7]  = '{3'b010, 8'h55,  2, 8'h3C, 8'h00, 6'h00, 3'b001, 1'b0};
        tbl[8]  = '{3'b000, 8'h55,  4, 8'h3C, 8'h00, 6'h00, 3'b001, 1'b0};
        tbl[9]  = '{3'b001, 8'h05,  6, 8'h05, 8'h00, 6'h00, 3'b001, 1'b0};
        tbl[10] = '{3'b000, 8'h05,  1, 8'h05, 8'h00, 6'h00, 3'b001, 1'b0};
        tbl[11] = '{3'b010, 8'h03,  6, 8'h05, 8'h03, 6'h00, 3'b011, 1'b0};
        tbl[12] = '{3'b000, 8'h03,  1, 8'h05, 8'h03, 6'h00, 3'b011, 1'b0};
        tbl[13] = '{3'b100, 8'hE0,  6, 8'h05, 8'h03, 6'h20, 3'b111, 1'b1}; // set complete
        tbl[14] = '{3'b000, 8'hE0,  2, 8'h05, 8'h03, 6'h20, 3'b111, 1'b0};
        tbl[15] = '{3'b001, 8'h07,  6, 8'h07, 8'h03, 6'h20, 3'b111, 1'b1}; // reload pulses

        btn = '0;
        sw  = '0;
        rst = 1'b0;
        model_clear();
        do_reset();

        for (int k = 0; k < 16; k++) begin
            btn = tbl[k].btn;
            sw  = tbl[k].sw;
            repeat (tbl[k].ncyc) tick();
            chk($sformatf("vec%0d", k), outs(),
                {6'd0, tbl[k].a, tbl[k].b, tbl[k].op, tbl[k].ld, tbl[k].upd});
        end

        // UPDATE is a single-cycle pulse after the full set is done.
        btn = '0;
        tick();
        chk("upd_drop", {31'd0, update}, 32'd0);

        // Simultaneous press from reset.
        btn = '0;
        do_reset();
        btn = 3'b111;
        sw  = 8'hA5;
        repeat (5) tick();
        chk("simul_pre", outs(), 32'd0);
        tick();
        chk("simul_load", outs(), {6'd0, 8'hA5, 8'hA5, 6'h25, 3'b111, 1'b1});
        tick();
        chk("simul_one_pulse", outs(), {6'd0, 8'hA5, 8'hA5, 6'h25, 3'b111, 1'b0});

        // Reset mid-debounce with the button still held.
        btn = '0;
        do_reset();
        btn = 3'b001;
        sw  = 8'h11;
        repeat (4) tick();
        chk("middeb_pre", outs(), 32'd0);
        do_reset();
        sw = 8'h22;
        repeat (5) tick();
        chk("middeb_edge5", outs(), 32'd0);
        tick();
        chk("middeb_edge6", outs(), {6'd0, 8'h22, 8'h00, 6'h00, 3'b001, 1'b0});

        // Randomised button activity checked cycle by cycle against the model.
        btn = '0;
        do_reset();
        lvl = '0;
        for (int i = 0; i < 3; i++) hold[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (hold[i] == 0) begin
                    lvl[i]  = 1'($urandom_range(0, 1));
                    hold[i] = int'($urandom_range(1, 9));
                end
                hold[i]--;
            end
            btn = lvl;
            if ($urandom_range(0, 3) == 0) sw = 8'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_input_sequencer.md
Name: alu_input_sequencer

Overview:
- Front-end controller for the board-level ALU. It takes the raw push-buttons and slide switches, and produces clean, registered operands and an opcode for the ALU datapath.
- Each button is synchronised and debounced. A qualified press captures the switch bank into operand A, operand B or the opcode register.
- The block tracks which operands are loaded and pulses an update strobe once the ALU inputs form a complete set.
- It sits between the board I/O (SWITCHES/BUTTONS) and the ALU core inside ALU_top.

Parameters:
- SIZEDATA, 8, width of SWITCHES, DATA_A and DATA_B.
- N_BUTTONS, 3, number of buttons; fixed at 3 (bit0=load A, bit1=load B, bit2=load OP).
- SIZEOP, 6, opcode width; taken from SWITCHES[SIZEOP-1:0]; must be ≤ SIZEDATA.
- DEBOUNCE_CYCLES, 1000000, consecutive synchronised-high cycles needed to qualify a press; must be ≥1. Counter width is $clog2(DEBOUNCE_CYCLES+1).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- SWITCHES  in  SIZEDATA  data/opcode switch bank; quasi-static, sampled unsynchronised at the load edge.
- BUTTONS  in  N_BUTTONS  raw, asynchronous, bouncing push-buttons.
- DATA_A  out  SIZEDATA  registered operand A to ALU.
- DATA_B  out  SIZEDATA  registered operand B to ALU.
- OPCODE  out  SIZEOP  registered ALU operation code.
- LOADED  out  3  sticky flags {OP,B,A}: register written since reset.
- UPDATE  out  1  one-cycle pulse: a load just completed and all LOADED bits are set.

Behaviour:
- Reset (async assert, sync release in the clock domain): DATA_A=0, DATA_B=0, OPCODE=0, LOADED=3'b000, UPDATE=0. All synchroniser flops and debounce counters are cleared.
- Per button i, synchroniser: two flops, ff1 <= BUTTONS[i], sync <= ff1.
- Per button i, debounce counter cnt_i:
  - If sync=0: cnt_i <= 0.
  - Else if cnt_i < DEBOUNCE_CYCLES: cnt_i <= cnt_i+1.
  - Else hold (saturate).
- Press event press_i is combinational and equals (sync==1 && cnt_i==DEBOUNCE_CYCLES-1). It fires exactly once per held press.
- Load on a press event, at that same clock edge:
  - press_0: DATA_A <= SWITCHES, LOADED[0] <= 1.
  - press_1: DATA_B <= SWITCHES, LOADED[1] <= 1.
  - press_2: OPCODE <= SWITCHES[SIZEOP-1:0], LOADED[2] <= 1.
- Latency: take the first edge that samples BUTTONS[i]=1 into ff1 as edge 1. The register updates on edge DEBOUNCE_CYCLES+2, provided the button stays high throughout.
- Glitch rejection: any low sample reaching sync before the counter saturates restarts qualification from 0. A pulse shorter than DEBOUNCE_CYCLES cycles (post-sync) produces no load.
- Held button: exactly one load. A new load requires sync to return to 0 for ≥1 cycle and then requalify.
- Simultaneous events: multiple press_i in the same cycle are all serviced in that cycle. All registers load the same SWITCHES value; there is no priority and no event is dropped.
- UPDATE <= (any press_i) && (LOADED_next == 3'b111), registered, high for exactly one cycle.
  - Fires on every subsequent reload once the set is complete.
  - Fires once if several loads coincide.
  - Never fires while any LOADED bit is 0.
- Registers hold their value between loads; SWITCHES changes without a press have no effect.
- Reset mid-debounce: partial qualification is discarded. A button still held after reset release requalifies from scratch: load at edge D+2 counted from the first post-reset sample.

Test Plan (DEBOUNCE_CYCLES=4, SIZEDATA=8, SIZEOP=6):
- Reset check: assert RESET with buttons idle -> all outputs 0 immediately (asynchronous, no clock edge needed).
- Basic load: SWITCHES=8'h3C, hold BUTTONS=3'b001 → DATA_A=8'h3C at edge 6 after first sample, LOADED=3'b001, UPDATE stays 0. Hold 50 more cycles with SWITCHES=8'hFF → DATA_A stays 8'h3C.
- Glitch rejection: BUTTONS[1] high for 3 cycles, bouncing 1-0-1-1, then low → DATA_B stays 0 and LOADED[1]=0.
- Full-set sequence: load A=8'h05, B=8'h03, then OP with SWITCHES=8'hE0 → OPCODE=6'h20, LOADED=3'b111, UPDATE high exactly 1 cycle after the OP load. Reload A=8'h07 → UPDATE pulses again.
- Simultaneous press: BUTTONS=3'b111 with SWITCHES=8'hA5 from reset → DATA_A=DATA_B=8'hA5, OPCODE=6'h25 on the same edge, and a single UPDATE pulse.
- Reset mid-debounce: hold BUTTONS[0] and assert RESET after 3 synced cycles, keep the button held → no load before reset. After release, DATA_A loads at edge 6 counted from the first post-reset sample.
